serial_adder: RTL and testbench

- Multi-cycle, parametrised adder/subtractor for the datapath labs.
- Processes two WIDTH-bit operands DIGIT bits per clock, with a registered carry between digits.
- Uses a start/busy/done handshake and holds the result until the next operation completes.
- Successor to the single-bit combinational adder cells: adds width/rate parameters, subtract mode, and sequential control.

---
 rtl/serial_adder.sv | 149 ++++++++++++++
 tb/tb_serial_adder.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: DIGIT bits of a and b per clock, result after WIDTH/DIGIT cycles.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic [DIGIT:0]   dig_res;
  logic [DIGIT-1:0] dig_sum;
  logic             dig_carry;
  logic [WIDTH-1:0] psum_shift;
  logic             cnt_last;

  // One digit of the ripple: low DIGIT bits of each shift register plus the stored carry.
  assign dig_res   = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
  assign dig_sum   = dig_res[DIGIT-1:0];
  assign dig_carry = dig_res[DIGIT];
  assign cnt_last  = (cnt_q == CW'(N - 1));

  // Partial sum fills from the MSB end so the first digit ends up in the low bits.
  generate
    if (WIDTH > DIGIT) begin : gen_psum_shift
      assign psum_shift = {dig_sum, psum_q[WIDTH-1:DIGIT]};
    end else begin : gen_psum_whole
      assign psum_shift = dig_sum;
    end
  endgenerate

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_q, ovf_d;
  logic msb_cin;

  // Carry into the top bit of the digit, recovered from that bit's sum and operands.
  assign msb_cin = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ dig_sum[DIGIT-1];
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    psum_d  = psum_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub;
          cnt_d   = '0;
          state_d = RUN;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = dig_carry;
        psum_d  = psum_shift;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_last) begin
          sum_d   = psum_shift;
          cout_d  = dig_carry;
`ifdef SERIAL_ADDER_OVF_EN
          ovf_d   = msb_cin ^ dig_carry;
`endif
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      psum_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      psum_q  <= psum_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: an 8-bit/1-bit-digit instance and a 16-bit/4-bit-digit instance,
// compared against an arithmetic reference model.
module tb_serial_adder;

  localparam int N8  = 8;
  localparam int N16 = 4;
  localparam logic [7:0] DA [5] = '{8'h0F, 8'hFF, 8'h7F, 8'h05, 8'h07};
  localparam logic [7:0] DB [5] = '{8'h01, 8'h01, 8'h01, 8'h07, 8'h05};
  localparam logic       DS [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;

  logic        start8 = 1'b0, sub8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, cout8;
  logic [7:0]  sum8;

  logic        start16 = 1'b0, sub16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16, cout16;
  logic [15:0] sum16;
`ifdef SERIAL_ADDER_OVF_EN
  logic        ovf8, ovf16;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8), .DIGIT(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_adder #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .sub(sub16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf16)
`endif
  );

  // Reference: plain modular arithmetic plus sign-rule overflow.
  function automatic void model(input int w, input logic [15:0] a, input logic [15:0] b,
                                input logic s, output logic [15:0] sm, output logic co,
                                output logic ov);
    int unsigned mask, bb, tot;
    logic sa, sb, sr;
    mask = (32'd1 << w) - 32'd1;
    bb   = s ? (~{16'h0, b} & mask) : {16'h0, b};
    tot  = {16'h0, a} + bb + {31'd0, s};
    sm   = 16'(tot & mask);
    co   = ((tot >> w) & 32'd1) != 0;
    sa   = a[w-1];
    sb   = b[w-1];
    sr   = sm[w-1];
    ov   = s ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
  endfunction

  // Drives one 8-bit operation and records what the DUT did; the callers judge it.
  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic s, input bit noise,
                         output int lat, output bit busy_all, output bit held,
                         output logic [7:0] so, output logic co, output logic oo,
                         output bit done_one);
    logic [7:0] prev;
    prev = sum8;
    @(negedge clk);
    a8 = a; b8 = b; sub8 = s; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = -1; busy_all = 1'b1; held = 1'b1; so = '0; co = 1'b0; oo = 1'b0;
    for (int c = 0; c <= N8 + 4 && lat < 0; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      if (done8 === 1'b1) begin
        lat = c; so = sum8; co = cout8;
`ifdef SERIAL_ADDER_OVF_EN
        oo = ovf8;
`endif
      end else begin
        if (busy8 !== 1'b1) busy_all = 1'b0;
        if (sum8 !== prev) held = 1'b0;
      end
      if (noise) begin
        if (c == 3) begin
          a8 = 8'hAA; b8 = 8'h55; sub8 = ~s; start8 = 1'b1;
        end else begin
          start8 = 1'b0;
        end
      end
    end
    @(posedge clk); #1;
    done_one = (done8 === 1'b0) && (busy8 === 1'b0);
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    checks++; if ({busy8, done8, cout8} !== 3'b000 || sum8 !== 8'h00) begin
      errors++; $display("FAIL reset8 got busy=%b done=%b sum=%h cout=%b expected 0 0 00 0", busy8, done8, sum8, cout8);
    end
    checks++; if ({busy16, done16, cout16} !== 3'b000 || sum16 !== 16'h0) begin
      errors++; $display("FAIL reset16 got busy=%b done=%b sum=%h cout=%b expected 0 0 0000 0", busy16, done16, sum16, cout16);
    end
`ifdef SERIAL_ADDER_OVF_EN
    checks++; if (ovf8 !== 1'b0 || ovf16 !== 1'b0) begin
      errors++; $display("FAIL reset_ovf got %b %b expected 0 0", ovf8, ovf16);
    end
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    int lat; bit ba, hd, d1; logic [7:0] so; logic co, oo;
    logic [15:0] esm; logic eco, eov;
    for (int i = 0; i < 5; i++) begin
      model(8, {8'h0, DA[i]}, {8'h0, DB[i]}, DS[i], esm, eco, eov);
      run_op8(DA[i], DB[i], DS[i], 1'b0, lat, ba, hd, so, co, oo, d1);
      $display("op8 a=%h b=%h sub=%b -> lat=%0d sum=%h cout=%b ovf=%b (ref %h %b %b)",
               DA[i], DB[i], DS[i], lat, so, co, oo, esm[7:0], eco, eov);
      checks++; if (lat !== N8) begin errors++; $display("FAIL dir_latency[%0d] got %0d expected %0d", i, lat, N8); end
      checks++; if (!ba) begin errors++; $display("FAIL dir_busy[%0d] got busy low during run expected high", i); end
      checks++; if (!hd) begin errors++; $display("FAIL dir_hold[%0d] got sum changed during run expected held", i); end
      checks++; if (so !== esm[7:0]) begin errors++; $display("FAIL dir_sum[%0d] got %h expected %h", i, so, esm[7:0]); end
      checks++; if (co !== eco) begin errors++; $display("FAIL dir_cout[%0d] got %b expected %b", i, co, eco); end
      checks++; if (!d1) begin errors++; $display("FAIL dir_done_pulse[%0d] got done/busy high after pulse expected idle", i); end
`ifdef SERIAL_ADDER_OVF_EN
      checks++; if (oo !== eov) begin errors++; $display("FAIL dir_ovf[%0d] got %b expected %b", i, oo, eov); end
`endif
    end
  endtask

  task automatic test_random();
    int lat; bit ba, hd, d1; logic [7:0] so, ra, rb; logic co, oo, rs;
    logic [15:0] esm; logic eco, eov;
    for (int i = 0; i < 16; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom_range(0, 1));
      model(8, {8'h0, ra}, {8'h0, rb}, rs, esm, eco, eov);
      run_op8(ra, rb, rs, 1'b0, lat, ba, hd, so, co, oo, d1);
      $display("op8 a=%h b=%h sub=%b -> lat=%0d sum=%h cout=%b ovf=%b (ref %h %b %b)",
               ra, rb, rs, lat, so, co, oo, esm[7:0], eco, eov);
      checks++; if (lat !== N8 || !ba || !d1) begin
        errors++; $display("FAIL rnd_timing[%0d] got lat=%0d busy_ok=%b pulse_ok=%b expected %0d 1 1", i, lat, ba, d1, N8);
      end
      checks++; if ({co, so} !== {eco, esm[7:0]}) begin
        errors++; $display("FAIL rnd_result[%0d] got cout=%b sum=%h expected %b %h", i, co, so, eco, esm[7:0]);
      end
`ifdef SERIAL_ADDER_OVF_EN
      checks++; if (oo !== eov) begin errors++; $display("FAIL rnd_ovf[%0d] got %b expected %b", i, oo, eov); end
`endif
    end
  endtask

  task automatic test_run_ignore();
    int lat; bit ba, hd, d1; logic [7:0] so; logic co, oo;
    logic [15:0] esm; logic eco, eov;
    model(8, 16'h0033, 16'h0044, 1'b0, esm, eco, eov);
    run_op8(8'h33, 8'h44, 1'b0, 1'b1, lat, ba, hd, so, co, oo, d1);
    $display("op8 a=33 b=44 sub=0 with mid-run noise -> lat=%0d sum=%h cout=%b ovf=%b (ref ovf %b)", lat, so, co, oo, eov);
    checks++; if (lat !== N8 || !ba) begin
      errors++; $display("FAIL ignore_timing got lat=%0d busy_ok=%b expected %0d 1", lat, ba, N8);
    end
    checks++; if (!hd) begin errors++; $display("FAIL ignore_hold got sum changed during run expected held"); end
    checks++; if ({co, so} !== {eco, esm[7:0]}) begin
      errors++; $display("FAIL ignore_result got cout=%b sum=%h expected %b %h", co, so, eco, esm[7:0]);
    end
    checks++; if (!d1) begin errors++; $display("FAIL ignore_no_requeue got busy/done after pulse expected idle"); end
  endtask

  task automatic test_reset_midop();
    int lat; bit ba, hd, d1, saw; logic [7:0] so; logic co, oo;
    logic [15:0] esm; logic eco, eov;
    run_op8(8'hF0, 8'h34, 1'b0, 1'b0, lat, ba, hd, so, co, oo, d1);
    checks++; if ({co, so} !== 9'h124) begin
      errors++; $display("FAIL prereset_result got cout=%b sum=%h expected 1 24", co, so);
    end
    @(negedge clk);
    a8 = 8'h11; b8 = 8'h22; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy8 !== 1'b1) begin errors++; $display("FAIL midop_busy got %b expected 1", busy8); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if ({busy8, done8, cout8} !== 3'b000 || sum8 !== 8'h00) begin
      errors++; $display("FAIL async_reset got busy=%b done=%b sum=%h cout=%b expected 0 0 00 0", busy8, done8, sum8, cout8);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (done8 !== 1'b0 || busy8 !== 1'b0) saw = 1'b1;
    end
    $display("op8 a=11 b=22 aborted by reset, activity after release=%b", saw);
    checks++; if (saw) begin errors++; $display("FAIL post_reset_quiet got done/busy activity expected none"); end
    model(8, 16'h0021, 16'h0043, 1'b1, esm, eco, eov);
    run_op8(8'h21, 8'h43, 1'b1, 1'b0, lat, ba, hd, so, co, oo, d1);
    $display("op8 a=21 b=43 sub=1 after reset -> lat=%0d sum=%h cout=%b ovf=%b (ref ovf %b)", lat, so, co, oo, eov);
    checks++; if (lat !== N8 || {co, so} !== {eco, esm[7:0]}) begin
      errors++; $display("FAIL post_reset_op got lat=%0d cout=%b sum=%h expected %0d %b %h", lat, co, so, N8, eco, esm[7:0]);
    end
  endtask

  task automatic test_wide();
    bit ba;
    logic [15:0] esm; logic eco, eov;
    model(16, 16'h1234, 16'h0FFF, 1'b0, esm, eco, eov);
    @(negedge clk);
    a16 = 16'h1234; b16 = 16'h0FFF; sub16 = 1'b0; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    ba = (busy16 === 1'b1) && (done16 === 1'b0) && (sum16 === 16'h0);
    for (int c = 1; c < N16; c++) begin
      @(posedge clk); #1;
      if (busy16 !== 1'b1 || done16 !== 1'b0 || sum16 !== 16'h0) ba = 1'b0;
    end
    @(posedge clk); #1;
    $display("op16 a=1234 b=0fff sub=0 -> done=%b sum=%h cout=%b (ref %h %b ovf %b)", done16, sum16, cout16, esm, eco, eov);
    checks++; if (!ba) begin errors++; $display("FAIL wide_run got busy/done/sum wrong during run expected 1/0/held"); end
    checks++; if (done16 !== 1'b1 || busy16 !== 1'b0) begin
      errors++; $display("FAIL wide_done got done=%b busy=%b expected 1 0", done16, busy16);
    end
    checks++; if ({cout16, sum16} !== {eco, esm}) begin
      errors++; $display("FAIL wide_result got cout=%b sum=%h expected %b %h", cout16, sum16, eco, esm);
    end
    @(posedge clk); #1;
    checks++; if (done16 !== 1'b0) begin errors++; $display("FAIL wide_pulse got done=%b expected 0", done16); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] oa [6], ob [6];
    logic        os [6];
    logic [15:0] esm; logic eco, eov;
    bit ba;
    oa[0] = 16'h1234; ob[0] = 16'h0FFF; os[0] = 1'b0;
    for (int i = 1; i < 6; i++) begin
      oa[i] = 16'($urandom); ob[i] = 16'($urandom); os[i] = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    a16 = oa[0]; b16 = ob[0]; sub16 = os[0]; start16 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      checks++; if (busy16 !== 1'b1 || done16 !== 1'b0) begin
        errors++; $display("FAIL b2b_accept[%0d] got busy=%b done=%b expected 1 0", i, busy16, done16);
      end
      if (i < 5) begin
        a16 = oa[i+1]; b16 = ob[i+1]; sub16 = os[i+1];
      end else begin
        start16 = 1'b0;
      end
      ba = 1'b1;
      for (int c = 1; c < N16; c++) begin
        @(posedge clk); #1;
        if (busy16 !== 1'b1 || done16 !== 1'b0) ba = 1'b0;
      end
      @(posedge clk); #1;
      model(16, oa[i], ob[i], os[i], esm, eco, eov);
      $display("op16 a=%h b=%h sub=%b back-to-back -> done=%b sum=%h cout=%b (ref %h %b ovf %b)",
               oa[i], ob[i], os[i], done16, sum16, cout16, esm, eco, eov);
      checks++; if (!ba || done16 !== 1'b1 || busy16 !== 1'b0) begin
        errors++; $display("FAIL b2b_timing[%0d] got run_ok=%b done=%b busy=%b expected 1 1 0", i, ba, done16, busy16);
      end
      checks++; if ({cout16, sum16} !== {eco, esm}) begin
        errors++; $display("FAIL b2b_result[%0d] got cout=%b sum=%h expected %b %h", i, cout16, sum16, eco, esm);
      end
`ifdef SERIAL_ADDER_OVF_EN
      checks++; if (ovf16 !== eov) begin errors++; $display("FAIL b2b_ovf[%0d] got %b expected %b", i, ovf16, eov); end
`endif
    end
    @(posedge clk); #1;
    checks++; if (done16 !== 1'b0 || busy16 !== 1'b0) begin
      errors++; $display("FAIL b2b_idle got done=%b busy=%b expected 0 0", done16, busy16);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_run_ignore();
    test_reset_midop();
    test_wide();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
